// File: rtl/ser_wide_narrow.sv
`default_nettype none
// ============================================================================
// Module   : ser_wide_narrow
// Brief    : Wide-to-narrow lane serializer with ready/valid on both sides.
// Revision : 1.0  initial release
// ============================================================================
module ser_wide_narrow #(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                               clk_4f,
  input  logic                               reset,
  input  logic [IN_W-1:0]                    data_in,
  input  logic [$clog2(IN_W/OUT_W)-1:0]      len_in,
  input  logic                               valid_in,
  output logic                               ready_in,
  output logic [OUT_W-1:0]                   data_out,
  output logic                               valid_out,
  output logic                               last_out,
  input  logic                               ready_out,
  output logic                               busy
);

  localparam int C_LANES = IN_W / OUT_W;
  localparam int C_LW    = $clog2(C_LANES);
  localparam int C_POS0  = MSB_FIRST ? (C_LANES - 1) : 0;

  if ((IN_W % OUT_W) != 0) begin : g_chk_div
    $fatal(1, "ser_wide_narrow: IN_W must be a multiple of OUT_W");
  end
  if ((C_LANES < 2) || ((C_LANES & (C_LANES - 1)) != 0)) begin : g_chk_pow2
    $fatal(1, "ser_wide_narrow: IN_W/OUT_W must be a power of 2 and >= 2");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [IN_W-1:0]   r_hold,  w_hold_nxt;
  logic [C_LW-1:0]   r_len,   w_len_nxt;
  logic [C_LW-1:0]   r_idx,   w_idx_nxt;
  logic [OUT_W-1:0]  r_data,  w_data_nxt;
  logic              r_last,  w_last_nxt;

  logic [OUT_W-1:0]  w_hold_lane [C_LANES];
  logic [OUT_W-1:0]  w_first_lane;
  logic [C_LW-1:0]   w_idx_inc;
  logic              w_valid, w_final, w_accept, w_advance;

  // Physical lane position depends on the configured lane order.
  for (genvar gi = 0; gi < C_LANES; gi++) begin : g_lane
    localparam int C_POS = MSB_FIRST ? (C_LANES - 1 - gi) : gi;
    assign w_hold_lane[gi] = r_hold[C_POS*OUT_W +: OUT_W];
  end

  assign w_first_lane = data_in[C_POS0*OUT_W +: OUT_W];
  assign w_idx_inc    = r_idx + 1'b1;
  assign w_valid      = (r_state == S_SEND);
  assign w_final      = w_valid & (r_idx == r_len);
  assign w_advance    = w_valid & ready_out;
  assign ready_in     = reset & (~w_valid | (w_final & ready_out));
  assign w_accept     = valid_in & ready_in;

  assign data_out  = r_data;
  assign valid_out = w_valid;
  assign last_out  = r_last;
  assign busy      = w_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SEND;
          w_hold_nxt  = data_in;
          w_len_nxt   = len_in;
          w_idx_nxt   = '0;
          w_data_nxt  = w_first_lane;
          w_last_nxt  = (len_in == '0);
        end
      end
      S_SEND: begin
        if (w_advance) begin
          if (!w_final) begin
            w_idx_nxt  = w_idx_inc;
            w_data_nxt = w_hold_lane[w_idx_inc];
            w_last_nxt = (w_idx_inc == r_len);
          end else if (w_accept) begin
            // Back-to-back: reload without leaving SEND, so no bubble lane.
            w_hold_nxt = data_in;
            w_len_nxt  = len_in;
            w_idx_nxt  = '0;
            w_data_nxt = w_first_lane;
            w_last_nxt = (len_in == '0);
          end else begin
            w_state_nxt = S_IDLE;
            w_data_nxt  = '0;
            w_last_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ser_wide_narrow.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser_wide_narrow
// Brief    : Directed bench for ser_wide_narrow (MSB 32/8, LSB 32/8, MSB 64/16).
// Revision : 1.0  initial release
// ============================================================================
module tb_ser_wide_narrow;

  logic clk_4f = 1'b0;
  logic reset;
  always #5 clk_4f = ~clk_4f;

  logic [31:0] d_data_in;  logic [1:0] d_len_in;  logic d_valid_in, d_ready_in;
  logic [7:0]  d_data_out; logic d_valid_out, d_last_out, d_ready_out, d_busy;
  logic [31:0] l_data_in;  logic [1:0] l_len_in;  logic l_valid_in, l_ready_in;
  logic [7:0]  l_data_out; logic l_valid_out, l_last_out, l_ready_out, l_busy;
  logic [63:0] x_data_in;  logic [1:0] x_len_in;  logic x_valid_in, x_ready_in;
  logic [15:0] x_data_out; logic x_valid_out, x_last_out, x_ready_out, x_busy;

  int n_vec = 0;
  int n_err = 0;

  ser_wide_narrow #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk_4f(clk_4f), .reset(reset), .data_in(d_data_in), .len_in(d_len_in),
    .valid_in(d_valid_in), .ready_in(d_ready_in), .data_out(d_data_out),
    .valid_out(d_valid_out), .last_out(d_last_out), .ready_out(d_ready_out), .busy(d_busy));

  ser_wide_narrow #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk_4f(clk_4f), .reset(reset), .data_in(l_data_in), .len_in(l_len_in),
    .valid_in(l_valid_in), .ready_in(l_ready_in), .data_out(l_data_out),
    .valid_out(l_valid_out), .last_out(l_last_out), .ready_out(l_ready_out), .busy(l_busy));

  ser_wide_narrow #(.IN_W(64), .OUT_W(16), .MSB_FIRST(1'b1)) u_wide (
    .clk_4f(clk_4f), .reset(reset), .data_in(x_data_in), .len_in(x_len_in),
    .valid_in(x_valid_in), .ready_in(x_ready_in), .data_out(x_data_out),
    .valid_out(x_valid_out), .last_out(x_last_out), .ready_out(x_ready_out), .busy(x_busy));

  task automatic tick;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    d_valid_in = 0; l_valid_in = 0; x_valid_in = 0;
    d_ready_out = 1; l_ready_out = 1; x_ready_out = 1;
    d_data_in = '0; l_data_in = '0; x_data_in = '0;
    d_len_in = '0; l_len_in = '0; x_len_in = '0;
    tick(); tick();
    n_vec++;
    if ({d_valid_out, d_last_out, d_busy, d_ready_in, d_data_out} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_msb: got v=%b l=%b b=%b rdy=%b d=%h, expected all 0",
               d_valid_out, d_last_out, d_busy, d_ready_in, d_data_out);
    end
    n_vec++;
    if ({l_valid_out, l_last_out, l_busy, l_ready_in, l_data_out} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_lsb: got v=%b l=%b b=%b rdy=%b d=%h, expected all 0",
               l_valid_out, l_last_out, l_busy, l_ready_in, l_data_out);
    end
    n_vec++;
    if ({x_valid_out, x_last_out, x_busy, x_ready_in, x_data_out} !== 20'h00000) begin
      n_err++;
      $display("FAIL reset_wide: got v=%b l=%b b=%b rdy=%b d=%h, expected all 0",
               x_valid_out, x_last_out, x_busy, x_ready_in, x_data_out);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if (d_ready_in !== 1'b1) begin
      n_err++;
      $display("FAIL idle_ready_in: got %b expected 1", d_ready_in);
    end
  endtask

  task automatic test_basic;
    logic [7:0] exp_d [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    d_data_in = 32'hA1B2C3D4; d_len_in = 2'd3; d_valid_in = 1; d_ready_out = 1;
    tick();
    d_valid_in = 0; d_data_in = 32'hFFFF_FFFF;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({d_valid_out, d_busy, d_last_out, d_ready_in, d_data_out} !==
          {1'b1, 1'b1, (k == 3), (k == 3), exp_d[k]}) begin
        n_err++;
        $display("FAIL basic_lane%0d: got v=%b b=%b l=%b rdy=%b d=%h, expected v=1 b=1 l=%b rdy=%b d=%h",
                 k, d_valid_out, d_busy, d_last_out, d_ready_in, d_data_out, (k == 3), (k == 3), exp_d[k]);
      end
      tick();
    end
    n_vec++;
    if ({d_valid_out, d_last_out, d_busy, d_data_out} !== 11'h000) begin
      n_err++;
      $display("FAIL basic_idle: got v=%b l=%b b=%b d=%h, expected all 0",
               d_valid_out, d_last_out, d_busy, d_data_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_d [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    d_data_in = 32'h11223344; d_len_in = 2'd3; d_valid_in = 1; d_ready_out = 1;
    tick();
    d_data_in = 32'h55667788;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) d_valid_in = 0;
      #1;
      n_vec++;
      if ({d_valid_out, d_last_out, d_ready_in, d_data_out} !==
          {1'b1, (k == 3 || k == 7), (k == 3 || k == 7), exp_d[k]}) begin
        n_err++;
        $display("FAIL b2b_lane%0d: got v=%b l=%b rdy=%b d=%h, expected v=1 l=%b rdy=%b d=%h",
                 k, d_valid_out, d_last_out, d_ready_in, d_data_out,
                 (k == 3 || k == 7), (k == 3 || k == 7), exp_d[k]);
      end
      tick();
    end
    n_vec++;
    if (d_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: got valid_out=%b expected 0", d_valid_out);
    end
  endtask

  task automatic test_backpressure;
    d_data_in = 32'hDEADBEEF; d_len_in = 2'd3; d_valid_in = 1; d_ready_out = 1;
    tick();
    d_valid_in = 0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      d_ready_out = 0;
      #1;
      n_vec++;
      if ({d_valid_out, d_last_out, d_ready_in, d_data_out} !== {3'b100, 8'hBE}) begin
        n_err++;
        $display("FAIL stall%0d: got v=%b l=%b rdy=%b d=%h, expected v=1 l=0 rdy=0 d=be",
                 k, d_valid_out, d_last_out, d_ready_in, d_data_out);
      end
      tick();
    end
    d_ready_out = 1;
    #1;
    n_vec++;
    if ({d_valid_out, d_last_out, d_data_out} !== {2'b10, 8'hBE}) begin
      n_err++;
      $display("FAIL stall_release: got v=%b l=%b d=%h, expected v=1 l=0 d=be",
               d_valid_out, d_last_out, d_data_out);
    end
    tick();
    n_vec++;
    if ({d_valid_out, d_last_out, d_ready_in, d_data_out} !== {3'b111, 8'hEF}) begin
      n_err++;
      $display("FAIL stall_resume: got v=%b l=%b rdy=%b d=%h, expected v=1 l=1 rdy=1 d=ef",
               d_valid_out, d_last_out, d_ready_in, d_data_out);
    end
    tick();
    n_vec++;
    if (d_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL stall_end: got valid_out=%b expected 0", d_valid_out);
    end
  endtask

  task automatic test_partial_lsb;
    l_data_in = 32'hCAFEF00D; l_len_in = 2'd1; l_valid_in = 1; l_ready_out = 1;
    tick();
    l_valid_in = 0;
    n_vec++;
    if ({l_valid_out, l_last_out, l_ready_in, l_data_out} !== {3'b100, 8'h0D}) begin
      n_err++;
      $display("FAIL lsb_lane0: got v=%b l=%b rdy=%b d=%h, expected v=1 l=0 rdy=0 d=0d",
               l_valid_out, l_last_out, l_ready_in, l_data_out);
    end
    tick();
    n_vec++;
    if ({l_valid_out, l_last_out, l_ready_in, l_data_out} !== {3'b111, 8'hF0}) begin
      n_err++;
      $display("FAIL lsb_lane1: got v=%b l=%b rdy=%b d=%h, expected v=1 l=1 rdy=1 d=f0",
               l_valid_out, l_last_out, l_ready_in, l_data_out);
    end
    tick();
    n_vec++;
    if ({l_valid_out, l_ready_in} !== 2'b01) begin
      n_err++;
      $display("FAIL lsb_end: got v=%b rdy=%b, expected v=0 rdy=1", l_valid_out, l_ready_in);
    end
  endtask

  task automatic test_reset_midword;
    logic [7:0] exp_d [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    d_data_in = 32'h01020304; d_len_in = 2'd3; d_valid_in = 1; d_ready_out = 1;
    tick();
    d_valid_in = 0;
    tick();
    reset = 0;
    #1;
    n_vec++;
    if ({d_data_out, d_ready_in} !== {8'h02, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_pre: got d=%h rdy=%b, expected d=02 rdy=0", d_data_out, d_ready_in);
    end
    tick();
    n_vec++;
    if ({d_valid_out, d_last_out, d_busy, d_data_out} !== 11'h000) begin
      n_err++;
      $display("FAIL midrst_clear: got v=%b l=%b b=%b d=%h, expected all 0",
               d_valid_out, d_last_out, d_busy, d_data_out);
    end
    reset = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_vec++;
      if (d_valid_out !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_quiet%0d: got valid_out=%b d=%h, expected 0",
                 k, d_valid_out, d_data_out);
      end
    end
    d_data_in = 32'h0A0B0C0D; d_valid_in = 1;
    tick();
    d_valid_in = 0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({d_valid_out, d_last_out, d_data_out} !== {1'b1, (k == 3), exp_d[k]}) begin
        n_err++;
        $display("FAIL midrst_new%0d: got v=%b l=%b d=%h, expected v=1 l=%b d=%h",
                 k, d_valid_out, d_last_out, d_data_out, (k == 3), exp_d[k]);
      end
      tick();
    end
  endtask

  task automatic test_wide;
    logic [15:0] exp_d [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
    x_data_in = 64'h0123456789ABCDEF; x_len_in = 2'd3; x_valid_in = 1; x_ready_out = 1;
    tick();
    x_valid_in = 0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({x_valid_out, x_last_out, x_data_out} !== {1'b1, (k == 3), exp_d[k]}) begin
        n_err++;
        $display("FAIL wide_lane%0d: got v=%b l=%b d=%h, expected v=1 l=%b d=%h",
                 k, x_valid_out, x_last_out, x_data_out, (k == 3), exp_d[k]);
      end
      tick();
    end
    x_len_in = 2'd0; x_valid_in = 1;
    tick();
    x_valid_in = 0;
    n_vec++;
    if ({x_valid_out, x_last_out, x_ready_in, x_data_out} !== {3'b111, 16'h0123}) begin
      n_err++;
      $display("FAIL wide_single: got v=%b l=%b rdy=%b d=%h, expected v=1 l=1 rdy=1 d=0123",
               x_valid_out, x_last_out, x_ready_in, x_data_out);
    end
    tick();
    n_vec++;
    if (x_valid_out !== 1'b0) begin
      n_err++;
      $display("FAIL wide_end: got valid_out=%b expected 0", x_valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_partial_lsb();
    test_reset_midword();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
